// File: rtl/axi_router_pkg.sv
// axi_router_pkg: shared state type and sizing helpers for the address router.
// Build option AXI_ROUTER_DECERR_EN selects the internal error slave.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif

package axi_router_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        ISSUE
    } state_e;

    localparam int DEF_NUM_SLAVES = 3;
    localparam int ERR_SLAVE      = DEF_NUM_SLAVES;

    function automatic int sel_width(input int n);
        return $clog2(n + 1);
    endfunction

    // The error slave sits one past the last real slave.
    function automatic int err_slave(input int n);
        return n;
    endfunction

endpackage

// File: rtl/axi_addr_router_if.sv
// axi_addr_router_if: master-side address channel bundle plus per-slave
// valid/ready and the response bookkeeping outputs.
interface axi_addr_router_if
    import axi_router_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int SEL_W      = sel_width(NUM_SLAVES)
);

    logic [`AXI_ADDR_BITS-1:0] ADDR;
    logic                      VALID;
    logic                      READY;
    logic [NUM_SLAVES-1:0]     VALID_S;
    logic [NUM_SLAVES-1:0]     READY_S;
    logic                      RESP_DONE;
    logic [SEL_W-1:0]          RESP_SEL;
    logic                      BUSY;

    modport slave (
        input  ADDR, VALID, READY_S, RESP_DONE,
        output READY, VALID_S, RESP_SEL, BUSY
    );

    modport master (
        output ADDR, VALID, READY_S, RESP_DONE,
        input  READY, VALID_S, RESP_SEL, BUSY
    );

endinterface

// File: rtl/axi_outstanding_cnt.sv
// axi_outstanding_cnt: saturating up/down counter of accepted-but-unanswered
// transactions; a decrement at zero is dropped.
module axi_outstanding_cnt #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [W-1:0] count_q, count_d;
    logic         dec_eff;

    assign full    = (count_q == W'(MAX));
    assign empty   = (count_q == '0);
    assign dec_eff = dec && !empty;

    always_comb begin
        count_d = count_q;
        if (inc && !dec_eff && !full) begin
            count_d = count_q + 1'b1;
        end else if (dec_eff && !inc) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_addr_router.sv
// axi_addr_router: registered AXI address-channel router, one master to
// NUM_SLAVES slaves. Define AXI_ROUTER_DECERR_EN for an internal error slave.
module axi_addr_router
    import axi_router_pkg::*;
#(
    parameter int NUM_SLAVES      = DEF_NUM_SLAVES,
    parameter int REGION_LSB      = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SEL_W           = sel_width(NUM_SLAVES)
) (
    input logic              ACLK,
    input logic              ARESETn,
    axi_addr_router_if.slave bus
);

    localparam int AW = `AXI_ADDR_BITS;
    localparam int FW = AW - REGION_LSB;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] resp_sel_q, resp_sel_d;
    logic [SEL_W-1:0] dec_sel, cand;
    logic [FW-1:0]    field;
    logic [NUM_SLAVES-1:0] valid_s;
    logic             ready;
    logic             accept;
    logic             allow;
    logic             full, empty;
    logic             unused_addr;

    assign field       = bus.ADDR[AW-1:REGION_LSB];
    assign unused_addr = ^bus.ADDR[REGION_LSB-1:0];

    always_comb begin
        dec_sel = field[SEL_W-1:0];
        if (field >= FW'(NUM_SLAVES)) begin
`ifdef AXI_ROUTER_DECERR_EN
            dec_sel = SEL_W'(err_slave(NUM_SLAVES));
`else
            dec_sel = SEL_W'(NUM_SLAVES - 1);
`endif
        end
    end

    // Same-slave requests may stack; a switch waits for the pipe to drain.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        resp_sel_d = resp_sel_q;
        valid_s    = '0;
        ready      = 1'b0;
        accept     = 1'b0;
        cand       = (state_q == IDLE) ? dec_sel : sel_q;
        allow      = empty || ((cand == resp_sel_q) && !full);
        unique case (state_q)
            IDLE: begin
                if (bus.VALID) begin
                    sel_d   = dec_sel;
                    state_d = allow ? ISSUE : STALL;
                end
            end
            STALL: begin
                if (!bus.VALID) begin
                    state_d = IDLE;
                end else if (allow) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                valid_s = NUM_SLAVES'(1) << sel_q;
                ready   = |(valid_s & bus.READY_S);
`ifdef AXI_ROUTER_DECERR_EN
                if (sel_q == SEL_W'(err_slave(NUM_SLAVES))) begin
                    ready = 1'b1;
                end
`endif
                if (ready) begin
                    accept     = 1'b1;
                    resp_sel_d = sel_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            resp_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            resp_sel_q <= resp_sel_d;
        end
    end

    axi_outstanding_cnt #(
        .MAX (MAX_OUTSTANDING)
    ) u_cnt (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .inc   (accept),
        .dec   (bus.RESP_DONE),
        .full  (full),
        .empty (empty)
    );

    assign bus.VALID_S  = valid_s;
    assign bus.READY    = ready;
    assign bus.RESP_SEL = resp_sel_q;
    assign bus.BUSY     = !empty;

endmodule

// File: tb/tb_axi_addr_router.sv
// tb_axi_addr_router: randomized bench for axi_addr_router with a
// transaction-level model of routing and outstanding-response rules.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif

module tb_axi_addr_router;

    localparam int NS   = 3;
    localparam int MAXO = 4;
    localparam int SW   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    axi_addr_router_if #(.NUM_SLAVES(NS), .SEL_W(SW)) bus ();

    axi_addr_router #(
        .NUM_SLAVES      (NS),
        .REGION_LSB      (16),
        .MAX_OUTSTANDING (MAXO),
        .SEL_W           (SW)
    ) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    int model_cnt = 0;
    int model_sel = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_target(input logic [31:0] a);
        int f;
        f = int'(a[31:16]);
        if (f < NS) return f;
`ifdef AXI_ROUTER_DECERR_EN
        return NS;
`else
        return NS - 1;
`endif
    endfunction

    function automatic bit allowed(input int t);
        return (model_cnt == 0) ||
               ((t == model_sel) && (model_cnt < MAXO));
    endfunction

    function automatic logic [2:0] onehot(input int t);
        logic [2:0] v;
        v = '0;
        if (t < NS) v[t] = 1'b1;
        return v;
    endfunction

    task automatic pulse_done(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            bus.RESP_DONE = 1'b1;
            tick();
            bus.RESP_DONE = 1'b0;
            if (model_cnt > 0) model_cnt--;
            checks++;
            if (bus.BUSY !== (model_cnt != 0)) begin
                failures++;
                $display("FAIL %s busy got=%b want=%b",
                         nm, bus.BUSY, (model_cnt != 0));
            end
        end
    endtask

    task automatic do_req(input logic [31:0] a, input int dly,
                          input bit done_hs, input string nm);
        int t;
        int guard;
        logic [2:0] oh;
        t  = exp_target(a);
        oh = onehot(t);
        bus.ADDR    = a;
        bus.VALID   = 1'b1;
        bus.READY_S = '0;
        tick();
        guard = 0;
        while (!allowed(t) && guard < MAXO + 2) begin
            checks++;
            if (bus.VALID_S !== 3'b000 || bus.READY !== 1'b0) begin
                failures++;
                $display("FAIL %s stall valid_s=%b ready=%b want 000/0",
                         nm, bus.VALID_S, bus.READY);
            end
            bus.RESP_DONE = 1'b1;
            tick();
            bus.RESP_DONE = 1'b0;
            if (model_cnt > 0) model_cnt--;
            tick();
            guard++;
        end
        if (!allowed(t)) begin
            failures++;
            $display("FAIL %s stall bound expired", nm);
        end
        checks++;
        if (bus.VALID_S !== oh) begin
            failures++;
            $display("FAIL %s issue valid_s got=%b want=%b",
                     nm, bus.VALID_S, oh);
        end
        if (t == NS) begin
            bus.READY_S = 3'($urandom);
            #1;
            checks++;
            if (bus.READY !== 1'b1) begin
                failures++;
                $display("FAIL %s decerr ready got=%b want=1",
                         nm, bus.READY);
            end
        end else begin
            for (int i = 0; i < dly; i++) begin
                bus.READY_S = 3'($urandom) & ~oh;
                #1;
                checks++;
                if (bus.READY !== 1'b0 || bus.VALID_S !== oh) begin
                    failures++;
                    $display("FAIL %s hold ready=%b valid_s=%b want 0/%b",
                             nm, bus.READY, bus.VALID_S, oh);
                end
                tick();
            end
            bus.READY_S = 3'($urandom) | oh;
            #1;
            checks++;
            if (bus.READY !== 1'b1) begin
                failures++;
                $display("FAIL %s ready got=%b want=1", nm, bus.READY);
            end
        end
        if (done_hs) bus.RESP_DONE = 1'b1;
        tick();
        if (!(done_hs && model_cnt > 0)) model_cnt++;
        model_sel = t;
        bus.VALID     = 1'b0;
        bus.RESP_DONE = 1'b0;
        bus.READY_S   = '0;
        checks++;
        if (bus.BUSY !== (model_cnt != 0) ||
            bus.RESP_SEL !== SW'(model_sel) ||
            bus.VALID_S !== 3'b000) begin
            failures++;
            $display("FAIL %s post busy=%b sel=%0d vs=%b want %b/%0d/000",
                     nm, bus.BUSY, bus.RESP_SEL, bus.VALID_S,
                     (model_cnt != 0), model_sel);
        end
    endtask

    task automatic test_reset();
        bus.ADDR      = '0;
        bus.VALID     = 1'b0;
        bus.READY_S   = '0;
        bus.RESP_DONE = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.READY !== 1'b0 || bus.VALID_S !== 3'b000 ||
            bus.RESP_SEL !== 2'd0 || bus.BUSY !== 1'b0) begin
            failures++;
            $display("FAIL reset rdy=%b vs=%b sel=%0d busy=%b want 0/000/0/0",
                     bus.READY, bus.VALID_S, bus.RESP_SEL, bus.BUSY);
        end
        rst_n = 1'b1;
        model_cnt = 0;
        model_sel = 0;
        tick();
    endtask

    task automatic test_basic();
        do_req(32'h0001_0000, 0, 1'b0, "basic");
        pulse_done(1, "basic_drain");
    endtask

    task automatic test_stall_other();
        do_req(32'h0000_0100, 1, 1'b0, "other_s0");
        do_req(32'h0002_0040, 0, 1'b0, "other_s2");
        pulse_done(1, "other_drain");
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            do_req(32'h0000_1234 + i, i % 2, 1'b0, "full_fill");
        end
        do_req(32'h0000_2000, 0, 1'b0, "full_fifth");
        do_req(32'h0000_3000, 1, 1'b0, "full_sixth");
        pulse_done(MAXO + 2, "full_drain");
    endtask

    task automatic test_simul();
        do_req(32'h0001_0010, 0, 1'b0, "simul_a");
        do_req(32'h0001_0020, 0, 1'b0, "simul_b");
        do_req(32'h0001_0030, 1, 1'b1, "simul_both");
        pulse_done(2, "simul_drain");
    endtask

    task automatic test_unmapped();
        do_req(32'h0007_0000, 0, 1'b0, "unmapped");
        do_req(32'h0005_0008, 1, 1'b0, "unmapped_b2b");
        pulse_done(2, "unmapped_drain");
    endtask

    task automatic test_valid_drop();
        do_req(32'h0000_0000, 0, 1'b0, "drop_s0");
        bus.ADDR  = 32'h0001_0000;
        bus.VALID = 1'b1;
        tick();
        bus.VALID = 1'b0;
        repeat (2) tick();
        checks++;
        if (bus.VALID_S !== 3'b000 || bus.BUSY !== 1'b1 ||
            bus.RESP_SEL !== 2'd0) begin
            failures++;
            $display("FAIL drop vs=%b busy=%b sel=%0d want 000/1/0",
                     bus.VALID_S, bus.BUSY, bus.RESP_SEL);
        end
        pulse_done(1, "drop_drain");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            do_req(32'h0002_0000 + 32'(i * 4), 0, 1'b0, "rmid_fill");
        end
        bus.ADDR    = 32'h0002_0100;
        bus.VALID   = 1'b1;
        bus.READY_S = '0;
        tick();
        checks++;
        if (bus.VALID_S !== 3'b100) begin
            failures++;
            $display("FAIL rmid issue vs=%b want=100", bus.VALID_S);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.VALID_S !== 3'b000 || bus.READY !== 1'b0 ||
            bus.BUSY !== 1'b0 || bus.RESP_SEL !== 2'd0) begin
            failures++;
            $display("FAIL rmid reset vs=%b rdy=%b busy=%b sel=%0d",
                     bus.VALID_S, bus.READY, bus.BUSY, bus.RESP_SEL);
        end
        bus.VALID = 1'b0;
        tick();
        rst_n = 1'b1;
        model_cnt = 0;
        model_sel = 0;
        tick();
        do_req(32'h0001_0000, 0, 1'b0, "rmid_after");
        pulse_done(1, "rmid_drain");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int f;
        for (int n = 0; n < 60; n++) begin
            f = ($urandom_range(0, 7) == 0) ?
                int'($urandom_range(3, 7)) : int'($urandom_range(0, 2));
            a = {16'(f), 16'($urandom)};
            do_req(a, int'($urandom_range(0, 2)),
                   ($urandom_range(0, 3) == 0), "random");
            if ($urandom_range(0, 2) == 0) begin
                pulse_done(int'($urandom_range(1, 2)), "random_done");
            end
        end
        pulse_done(MAXO, "random_drain");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_other();
        test_full();
        test_simul();
        test_unmapped();
        test_valid_drop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
